// File: rtl/window_5x5_gen.sv
// window_5x5_gen: streaming 5x5 window generator for 8-bit raster pixels.
//
// Buffers the previous four image lines. For every accepted pixel at x>=4, y>=4 it emits the
// 5x5 neighbourhood whose bottom-right corner is that pixel, registered one cycle after accept.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready    input pixel handshake; s_pixel is the 8-bit pixel in raster order
//   m_valid/m_ready    output window handshake
//   m_window           pixel(row r, col c) at [40*r+8*c +: 8]; r=0 top, c=0 left
//   m_last             high with the final window of a frame
//   m_cx, m_cy         window centre coordinates (only when WIN_COORD_EN is defined)
//
// Build option: define WIN_COORD_EN to add the m_cx/m_cy coordinate outputs.
module window_5x5_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_pixel,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [199:0] m_window,
  output logic         m_last
`ifdef WIN_COORD_EN
  ,
  output logic [15:0]  m_cx,
  output logic [15:0]  m_cy
`endif
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [199:0]  win_q, win_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [199:0]  m_window_q, m_window_d;

  // lb_q[0] holds line y-1, lb_q[3] holds line y-4.
  logic [7:0]    lb_q [4][IMG_WIDTH];
  logic [7:0]    col [5];

  logic accept;
  logic emit;

  assign s_ready  = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;
  assign emit     = accept && (x_q >= XW'(4)) && (y_q >= YW'(4));

  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_window = m_window_q;

  // Column entering the window, top (oldest line) to bottom (current pixel).
  always_comb begin
    col[0] = lb_q[3][x_q];
    col[1] = lb_q[2][x_q];
    col[2] = lb_q[1][x_q];
    col[3] = lb_q[0][x_q];
    col[4] = s_pixel;
  end

  always_comb begin
    win_d      = win_q;
    x_d        = x_q;
    y_d        = y_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_window_d = m_window_q;

    if (accept) begin
      // Each row shifts one pixel left; the new column lands at c=4.
      for (int r = 0; r < 5; r++) begin
        win_d[40*r +: 40] = {col[r], win_q[40*r+8 +: 32]};
      end
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (emit) begin
      m_valid_d  = 1'b1;
      m_window_d = win_d;
      m_last_d   = (x_q == XLast) && (y_q == YLast);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      win_q      <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_window_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      win_q      <= win_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_window_q <= m_window_d;
    end
  end

  // Line buffers are plain RAM: never reset, every entry rewritten before it is emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[3][x_q] <= lb_q[2][x_q];
      lb_q[2][x_q] <= lb_q[1][x_q];
      lb_q[1][x_q] <= lb_q[0][x_q];
      lb_q[0][x_q] <= s_pixel;
    end
  end

`ifdef WIN_COORD_EN
  logic [15:0] cx_q, cy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (emit) begin
      cx_q <= 16'(x_q) - 16'd2;
      cy_q <= 16'(y_q) - 16'd2;
    end
  end

  assign m_cx = cx_q;
  assign m_cy = cy_q;
`endif

endmodule

// File: tb/tb_window_5x5_gen.sv
module tb_window_5x5_gen;
  localparam int W = 8;
  localparam int H = 6;
  localparam int MaxCyc = 20000;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_pixel;
  logic         m_valid;
  logic         m_ready;
  logic [199:0] m_window;
  logic         m_last;
`ifdef WIN_COORD_EN
  logic [15:0]  m_cx;
  logic [15:0]  m_cy;
`endif

  always #5 clk = ~clk;

  window_5x5_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_pixel (s_pixel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_window(m_window),
    .m_last  (m_last)
`ifdef WIN_COORD_EN
    ,
    .m_cx    (m_cx),
    .m_cy    (m_cy)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   src_q[$];
  logic [199:0] exp_win[$];
  logic [199:0] got_win[$];
  bit           exp_last[$];
  bit           got_last[$];
  int           exp_cx[$];
  int           exp_cy[$];
  int           got_cx[$];
  int           got_cy[$];
  int           hold_viol;
  int           sready_viol;
  int           stall_cycles;
  bit           timed_out;

  // Reference: rebuild each frame as a 2-D image and cut the 5x5 block ending at (x,y).
  task automatic build_expected();
    logic [7:0]   img [H][W];
    logic [199:0] w;
    int x, y;
    exp_win.delete(); exp_last.delete(); exp_cx.delete(); exp_cy.delete();
    for (int idx = 0; idx < src_q.size(); idx++) begin
      x = idx % W;
      y = (idx / W) % H;
      img[y][x] = src_q[idx];
      if (x >= 4 && y >= 4) begin
        w = '0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            w[40*r+8*c +: 8] = img[y-4+r][x-4+c];
        exp_win.push_back(w);
        exp_last.push_back(x == W-1 && y == H-1);
        exp_cx.push_back(x - 2);
        exp_cy.push_back(y - 2);
      end
    end
  endtask

  // Streams src_q with random valid/ready gaps and collects every handshaked window.
  task automatic stream(input int vprob, input int rprob, input int stall_start);
    int i = 0;
    int cyc = 0;
    bit acc = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_last = 1'b0;
    logic [199:0] prev_win = '0;
    got_win.delete(); got_last.delete(); got_cx.delete(); got_cy.delete();
    hold_viol = 0; sready_viol = 0; stall_cycles = 0;
    while ((i < src_q.size() || m_valid || acc) && cyc < MaxCyc) begin
      @(posedge clk); #1;
      s_valid = (i < src_q.size()) && ($urandom_range(99) < vprob);
      s_pixel = s_valid ? src_q[i] : 8'($urandom);
      if (cyc >= stall_start && cyc < stall_start + 10) m_ready = 1'b0;
      else m_ready = ($urandom_range(99) < rprob);
      @(negedge clk);
      if (prev_stall && (m_valid !== 1'b1 || m_window !== prev_win || m_last !== prev_last))
        hold_viol++;
      if (m_valid && !m_ready) begin
        stall_cycles++;
        if (s_ready !== 1'b0) sready_viol++;
      end
      acc = s_valid && s_ready;
      if (acc) i++;
      if (m_valid && m_ready) begin
        got_win.push_back(m_window);
        got_last.push_back(m_last);
`ifdef WIN_COORD_EN
        got_cx.push_back(int'(m_cx));
        got_cy.push_back(int'(m_cy));
`endif
      end
      prev_stall = m_valid && !m_ready;
      prev_win = m_window;
      prev_last = m_last;
      cyc++;
    end
    timed_out = (cyc >= MaxCyc);
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic load_ramp(input int frames, input int offset_step);
    src_q.delete();
    for (int f = 0; f < frames; f++)
      for (int p = 0; p < W*H; p++) src_q.push_back(8'(p + f*offset_step));
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (m_window !== '0) begin errors++; $display("FAIL reset_m_window got %h want 0", m_window); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    logic [199:0] w;
    load_ramp(1, 0);
    build_expected();
    stream(100, 100, -100);
    checks++; if (timed_out) begin errors++; $display("FAIL ramp_timeout got 1 want 0"); end
    checks++; if (got_win.size() != 8) begin errors++; $display("FAIL ramp_count got %0d want 8", got_win.size()); end
    if (got_win.size() == 8) begin
      w = got_win[0];
      checks++; if (w[7:0] !== 8'd0 || w[39:32] !== 8'd4 || w[199:192] !== 8'd36) begin
        errors++; $display("FAIL ramp_first got %h want bytes 0/4/36", w); end
      w = got_win[7];
      checks++; if (w[7:0] !== 8'd11 || w[199:192] !== 8'd47 || got_last[7] !== 1'b1) begin
        errors++; $display("FAIL ramp_last got %h last %b want bytes 11/47 last 1", w, got_last[7]); end
`ifdef WIN_COORD_EN
      checks++; if (got_cx[0] != 2 || got_cy[0] != 2 || got_cx[7] != 5 || got_cy[7] != 3) begin
        errors++; $display("FAIL ramp_coord got %0d,%0d/%0d,%0d want 2,2/5,3",
                           got_cx[0], got_cy[0], got_cx[7], got_cy[7]); end
`endif
    end
    for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
      checks++; if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL ramp_win%0d got %h/%b want %h/%b", k, got_win[k], got_last[k],
                           exp_win[k], exp_last[k]); end
    end
  endtask

  task automatic test_constant();
    src_q.delete();
    for (int p = 0; p < W*H; p++) src_q.push_back(8'h80);
    stream(70, 100, -100);
    checks++; if (got_win.size() != 8 || timed_out) begin
      errors++; $display("FAIL const_count got %0d want 8", got_win.size()); end
    for (int k = 0; k < got_win.size(); k++) begin
      checks++; if (got_win[k] !== {25{8'h80}} || got_last[k] !== (k == 7)) begin
        errors++; $display("FAIL const_win%0d got %h/%b want all 80/%b", k, got_win[k],
                           got_last[k], k == 7); end
    end
  endtask

  task automatic test_backpressure();
    load_ramp(1, 0);
    build_expected();
    stream(100, 100, 40);
    checks++; if (stall_cycles < 9) begin
      errors++; $display("FAIL bp_stall_seen got %0d want >=9", stall_cycles); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d want 0", hold_viol); end
    checks++; if (sready_viol != 0) begin errors++; $display("FAIL bp_s_ready got %0d want 0", sready_viol); end
    checks++; if (got_win.size() != exp_win.size() || timed_out) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got_win.size(), exp_win.size()); end
    for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
      checks++; if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL bp_win%0d got %h want %h", k, got_win[k], exp_win[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] w;
    load_ramp(2, 100);
    build_expected();
    stream(100, 100, -100);
    checks++; if (got_win.size() != 16 || timed_out) begin
      errors++; $display("FAIL b2b_count got %0d want 16", got_win.size()); end
    if (got_win.size() == 16) begin
      w = got_win[8];
      checks++; if (w[7:0] !== 8'd100 || w[199:192] !== 8'd136) begin
        errors++; $display("FAIL b2b_win9 got %h want bytes 100/136", w); end
      checks++; if (got_last[7] !== 1'b1 || got_last[15] !== 1'b1 || got_last[8] !== 1'b0) begin
        errors++; $display("FAIL b2b_last got %b/%b/%b want 1/0/1", got_last[7], got_last[8],
                           got_last[15]); end
    end
    for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
      checks++; if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL b2b_win%0d got %h want %h", k, got_win[k], exp_win[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    int cyc = 0;
    // Feed until a window is pending and held by m_ready=0, then reset asynchronously.
    while (i < 37 && cyc < 200) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_pixel = 8'(i);
      m_ready = 1'b0;
      @(negedge clk);
      if (s_ready) i++;
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got %b want 1", m_valid); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_window !== '0) begin
      errors++; $display("FAIL rmid_clear got v%b l%b w%h want 0", m_valid, m_last, m_window); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    load_ramp(1, 0);
    build_expected();
    stream(100, 100, -100);
    checks++; if (got_win.size() != 8 || timed_out) begin
      errors++; $display("FAIL rmid_count got %0d want 8", got_win.size()); end
    for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
      checks++; if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL rmid_win%0d got %h want %h", k, got_win[k], exp_win[k]); end
    end
  endtask

  task automatic test_random();
    src_q.delete();
    for (int p = 0; p < 3*W*H; p++) src_q.push_back(8'($urandom));
    build_expected();
    stream(60, 55, -100);
    checks++; if (got_win.size() != exp_win.size() || timed_out) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_win.size(), exp_win.size()); end
    for (int k = 0; k < got_win.size() && k < exp_win.size(); k++) begin
      checks++; if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
        errors++; $display("FAIL rand_win%0d got %h/%b want %h/%b", k, got_win[k], got_last[k],
                           exp_win[k], exp_last[k]); end
`ifdef WIN_COORD_EN
      checks++; if (got_cx[k] != exp_cx[k] || got_cy[k] != exp_cy[k]) begin
        errors++; $display("FAIL rand_coord%0d got %0d,%0d want %0d,%0d", k, got_cx[k],
                           got_cy[k], exp_cx[k], exp_cy[k]); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_pixel = 8'h00;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_ramp();
    test_constant();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
